mips_insn_encoder: RTL

//  Inverse of the control/decode path: builds 32-bit MIPS instruction words from field-level requests.

---
 rtl/mips_insn_encoder_pkg.sv | 48 ++++
 rtl/mips_insn_encoder_pack.sv | 21 ++
 rtl/mips_insn_encoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_insn_encoder_pkg.sv
// rtl/mips_insn_encoder_pkg.sv - kind codes, opcode constants, state and field types for the encoder
package mips_insn_encoder_pkg;

   // Request kinds; 3 and 7 are reserved.
   localparam logic [2:0] ENC_R    = 3'd0;
   localparam logic [2:0] ENC_I    = 3'd1;
   localparam logic [2:0] ENC_J    = 3'd2;
   localparam logic [2:0] ENC_LI   = 3'd4;
   localparam logic [2:0] ENC_MOVE = 3'd5;
   localparam logic [2:0] ENC_NOP  = 3'd6;

   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] FN_ADDU  = 6'h21;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ONE    = 2'd1,
      ST_FIRST  = 2'd2,
      ST_SECOND = 2'd3
   } enc_state_e;

   typedef struct packed {
      logic [2:0]  kind;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [15:0] imm16;
      logic [25:0] target;
   } insn_fields_t;

   // Builds an I-type field set; used for the words LI expands into.
   function automatic insn_fields_t itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm16);
      insn_fields_t f;
      f       = '0;
      f.kind  = ENC_I;
      f.op    = op;
      f.rs    = rs;
      f.rt    = rt;
      f.imm16 = imm16;
      return f;
   endfunction

endpackage

// File: rtl/mips_insn_encoder_pack.sv
// rtl/mips_insn_encoder_pack.sv - combinational field packer producing one 32-bit MIPS word
module mips_insn_pack
   import mips_insn_encoder_pkg::*;
(
   input  insn_fields_t fields_i,
   output logic [31:0]  word_o
);

   // Lay out the fields according to the instruction format of the kind; NOP and reserved give zero.
   always_comb begin
      word_o = '0;
      case (fields_i.kind)
         ENC_R:    word_o = {6'b0, fields_i.rs, fields_i.rt, fields_i.rd, fields_i.shamt, fields_i.op};
         ENC_I:    word_o = {fields_i.op, fields_i.rs, fields_i.rt, fields_i.imm16};
         ENC_J:    word_o = {fields_i.op, fields_i.target};
         ENC_MOVE: word_o = {6'b0, fields_i.rs, 5'b0, fields_i.rd, 5'b0, FN_ADDU};
         default:  word_o = '0;
      endcase
   end

endmodule

// File: rtl/mips_insn_encoder.sv
// rtl/mips_insn_encoder.sv - field-level request to MIPS instruction word encoder with pseudo-op expansion
module mips_insn_encoder
   import mips_insn_encoder_pkg::*;
#(
   parameter bit ENABLE_PSEUDO = 1'b1,
   parameter bit LI_SHORT      = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_kind,
   input  logic [5:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_shamt,
   input  logic [31:0] in_imm,
   input  logic [25:0] in_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_opcode,
   output logic        out_last,
   output logic        err_illegal
);

   enc_state_e   state_q, state_d;
   logic [31:0]  word_q, word_d;
   logic [31:0]  pend_q, pend_d;
   logic         last_q, last_d;
   logic         err_q, err_d;

   insn_fields_t first_f, second_f;
   logic [31:0]  first_w, second_w;
   logic         is_pseudo, illegal, li_two, accept;

   // Decode the request into the first word's fields and the trailing ORI used by long LI.
   always_comb begin
      is_pseudo = (in_kind == ENC_LI) || (in_kind == ENC_MOVE) || (in_kind == ENC_NOP);
      illegal   = (in_kind == 3'd3) || (in_kind == 3'd7) || (is_pseudo && !ENABLE_PSEUDO);
      first_f        = '0;
      first_f.kind   = in_kind;
      first_f.op     = in_op;
      first_f.rs     = in_rs;
      first_f.rt     = in_rt;
      first_f.rd     = in_rd;
      first_f.shamt  = in_shamt;
      first_f.imm16  = in_imm[15:0];
      first_f.target = in_target;
      li_two = 1'b0;
      if (in_kind == ENC_LI) begin
         if (LI_SHORT && (in_imm[31:16] == 16'h0)) begin
            first_f = itype(OP_ORI, 5'd0, in_rt, in_imm[15:0]);
         end else if (LI_SHORT && (&in_imm[31:15])) begin
            first_f = itype(OP_ADDIU, 5'd0, in_rt, in_imm[15:0]);
         end else begin
            first_f = itype(OP_LUI, 5'd0, in_rt, in_imm[31:16]);
            li_two  = !LI_SHORT || (in_imm[15:0] != 16'h0);
         end
      end
      second_f = itype(OP_ORI, in_rt, in_rt, in_imm[15:0]);
   end

   mips_insn_pack u_pack_first  (.fields_i(first_f),  .word_o(first_w));
   mips_insn_pack u_pack_second (.fields_i(second_f), .word_o(second_w));

   assign in_ready    = (state_q == ST_IDLE) ||
                        (((state_q == ST_ONE) || (state_q == ST_SECOND)) && out_ready);
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_q != ST_IDLE);
   assign out_opcode  = word_q;
   assign out_last    = last_q;
   assign err_illegal = err_q;

   // Next state: drain the held word, advance LUI->ORI, and load a new legal request over a drained slot.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      pend_d  = pend_q;
      last_d  = last_q;
      err_d   = accept && illegal;
      if (out_valid && out_ready) begin
         if (state_q == ST_FIRST) begin
            state_d = ST_SECOND;
            word_d  = pend_q;
            last_d  = 1'b1;
         end else begin
            state_d = ST_IDLE;
         end
      end
      if (accept && !illegal) begin
         state_d = li_two ? ST_FIRST : ST_ONE;
         word_d  = first_w;
         last_d  = !li_two;
         pend_d  = second_w;
      end
   end

   // Output register, pending ORI and FSM state; reset drops any pending second word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         pend_q  <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

endmodule
